// File: rtl/adder_prefix_pipe_pkg.sv
// Shared constants for the pipelined Kogge-Stone adder: data width, prefix depth
// and how many prefix levels run ahead of the first pipeline register.
`ifndef LEN_DATA
`define LEN_DATA 32
`endif

package adder_prefix_pipe_pkg;

  localparam int DATA_W     = `LEN_DATA;
  localparam int NUM_LEVELS = $clog2(DATA_W);
  localparam int S1_LEVELS  = (NUM_LEVELS + 1) / 2;

endpackage

// File: rtl/adder_prefix_cell.sv
// One Kogge-Stone prefix node: merges a high (Gh,Ph) group with the adjacent
// lower (Gl,Pl) group.
module adder_prefix_cell (
  input  logic Gh,
  input  logic Ph,
  input  logic Gl,
  input  logic Pl,
  output logic G,
  output logic P
);

  assign G = Gh | (Ph & Gl);
  assign P = Ph & Pl;

endmodule

// File: rtl/adder_prefix_pipe.sv
// Two-stage pipelined Kogge-Stone adder with valid/ready handshakes and flush.
// Define ADDER_PREFIX_OVF_EN to add the registered signed-overflow output ovf_out.
module adder_prefix_pipe
  import adder_prefix_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] gen_in,
  input  logic [DATA_W-1:0] prop_in,
  input  logic              cin,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] sum_out,
  output logic              cout,
  output logic              out_valid,
  input  logic              out_ready
`ifdef ADDER_PREFIX_OVF_EN
  ,
  output logic              ovf_out
`endif
);

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_g;
  logic [DATA_W-1:0] r_s1_p;
  logic [DATA_W-1:0] r_s1_prop;
  logic              r_s1_cin;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_sum;
  logic              r_cout;

  logic              w_s1_load;
  logic              w_s2_load;
  logic [DATA_W-1:0] w_g0;
  logic [DATA_W-1:0] w_p0;
  logic [DATA_W-1:0] w_g_fin;
  logic [DATA_W-1:0] w_p_fin;
  logic [DATA_W-1:0] w_carry;
  logic [DATA_W-1:0] w_sum;
  logic              w_unused;

  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  // Carry-in folded into bit 0 so the tree needs no special carry path.
  always_comb begin
    w_g0    = gen_in;
    w_p0    = prop_in;
    w_g0[0] = gen_in[0] | (prop_in[0] & cin);
    w_p0[0] = 1'b0;
  end

  genvar gk, gi;
  generate
    for (gk = 1; gk <= NUM_LEVELS; gk++) begin : g_lvl
      localparam int DIST = 1 << (gk - 1);
      logic [DATA_W-1:0] w_gin;
      logic [DATA_W-1:0] w_pin;
      logic [DATA_W-1:0] w_g;
      logic [DATA_W-1:0] w_p;

      if (gk == 1) begin : g_src_in
        assign w_gin = w_g0;
        assign w_pin = w_p0;
      end else if (gk == S1_LEVELS + 1) begin : g_src_reg
        assign w_gin = r_s1_g;
        assign w_pin = r_s1_p;
      end else begin : g_src_prev
        assign w_gin = g_lvl[gk-1].w_g;
        assign w_pin = g_lvl[gk-1].w_p;
      end

      for (gi = 0; gi < DATA_W; gi++) begin : g_bit
        if (gi >= DIST) begin : g_node
          adder_prefix_cell u_cell (
            .Gh (w_gin[gi]),
            .Ph (w_pin[gi]),
            .Gl (w_gin[gi-DIST]),
            .Pl (w_pin[gi-DIST]),
            .G  (w_g[gi]),
            .P  (w_p[gi])
          );
        end else begin : g_pass
          assign w_g[gi] = w_gin[gi];
          assign w_p[gi] = w_pin[gi];
        end
      end
    end

    if (S1_LEVELS == NUM_LEVELS) begin : g_fin_reg
      assign w_g_fin = r_s1_g;
      assign w_p_fin = r_s1_p;
    end else begin : g_fin_tree
      assign w_g_fin = g_lvl[NUM_LEVELS].w_g;
      assign w_p_fin = g_lvl[NUM_LEVELS].w_p;
    end
  endgenerate

  // Group propagate of the last level has no consumer.
  assign w_unused = ^w_p_fin;

  assign w_carry = {w_g_fin[DATA_W-2:0], r_s1_cin};
  assign w_sum   = r_s1_prop ^ w_carry;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s1_load && in_valid) begin
      r_s1_g    <= g_lvl[S1_LEVELS].w_g;
      r_s1_p    <= g_lvl[S1_LEVELS].w_p;
      r_s1_prop <= prop_in;
      r_s1_cin  <= cin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_g_fin[DATA_W-1];
      end
    end
  end

  assign sum_out   = r_sum;
  assign cout      = r_cout;
  assign out_valid = r_out_valid;

`ifdef ADDER_PREFIX_OVF_EN
  logic r_ovf;

  // Overflow when the carry into the sign bit differs from the carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (!flush && w_s2_load && r_s1_valid) begin
      r_ovf <= w_carry[DATA_W-1] ^ w_g_fin[DATA_W-1];
    end
  end

  assign ovf_out = r_ovf;
`endif

endmodule

// File: doc/adder_prefix_pipe.md
ADDER_PREFIX_PIPE -- requirements
Module: adder_prefix_pipe

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port gen_in, input, `LEN_DATA, per-bit generate (A&B).
REQ-004 SHALL have port prop_in, input, `LEN_DATA, per-bit propagate (A^B).
REQ-005 SHALL have port cin, input, 1, carry into bit 0.
REQ-006 SHALL have port in_valid, input, 1, gen_in/prop_in/cin valid this cycle.
REQ-007 SHALL have port in_ready, output, 1, block accepts input this cycle.
REQ-008 SHALL have port flush, input, 1, discard all in-flight operations.
REQ-009 SHALL have port sum_out, output, `LEN_DATA, registered sum.
REQ-010 SHALL have port cout, output, 1, registered carry out of bit `LEN_DATA-1.
REQ-011 SHALL have port out_valid, output, 1, sum_out/cout valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-013 SHALL have port ovf_out, output, 1, signed overflow (present only with ADDER_PREFIX_OVF_EN).

Function
REQ-014 SHALL fold cin into bit 0 as g0' = gen_in[0] | (prop_in[0] & cin), p0' = 0, before the prefix tree.
REQ-015 SHALL compute group generate G[i:0] for all i with a Kogge-Stone tree of log2(`LEN_DATA) levels; carry into bit i+1 = G[i:0].
REQ-016 SHALL produce sum_out[i] = prop_in[i] ^ c[i], c[0] = cin; cout = G[`LEN_DATA-1:0]; arithmetic modulo 2^`LEN_DATA.
REQ-017 SHALL split the tree into two register stages: S1 registers (G,P,prop_in,cin) after levels 1..ceil(L/2); S2 registers sum/cout after remaining levels and sum XOR.
REQ-018 SHALL have latency exactly 2 cycles from input handshake to out_valid when out_ready held high.
REQ-019 SHALL transfer input when in_valid & in_ready; output when out_valid & out_ready.
REQ-020 SHALL load S2 when !out_valid | out_ready; load S1 when !s1_valid | S2 loads; in_ready = S1 load condition (combinational, no dependence on in_valid).
REQ-021 SHALL sustain one result per cycle with out_ready continuously high.
REQ-022 SHALL hold sum_out/cout/out_valid stable while out_valid & !out_ready.
REQ-023 SHALL, with both stages full and out_ready low, deassert in_ready; simultaneous out_ready rise and in_valid SHALL accept input same cycle (no bubble).
REQ-024 SHALL on flush clear s1_valid and out_valid next cycle; flush wins over simultaneous input handshake (input dropped); data registers need not clear.

Reset
REQ-025 SHALL on rst clear s1_valid, out_valid, sum_out, cout, ovf_out to 0; in_ready = 1 in the first cycle after reset.
REQ-026 SHALL treat rst mid-operation as flush plus output zeroing; rst has priority over flush and handshakes.

Configuration
REQ-027 SHALL compile ovf_out and its logic only when ADDER_PREFIX_OVF_EN is defined: ovf_out = c[`LEN_DATA-1] ^ cout, registered in S2 with sum_out.
REQ-028 SHALL, without ADDER_PREFIX_OVF_EN, omit port ovf_out and its registers; all other behaviour identical.

Structure
REQ-029 SHALL take `LEN_DATA from the shared main definitions file; prefix level count and S1 split point SHALL be derived constants there.
REQ-030 SHALL instantiate sub-module adder_prefix_cell (inputs Gh,Ph,Gl,Pl; outputs G=Gh|Ph&Gl, P=Ph&Pl) for every tree node.

Verification (LEN_DATA=32; gen=A&B, prop=A^B)
REQ-031 A=0xFFFFFFFF,B=0x00000001,cin=0 -> 2 cycles later sum_out=0x00000000, cout=1, ovf_out=0.
REQ-032 A=0x7FFFFFFF,B=0x00000000,cin=1 -> sum_out=0x80000000, cout=0, ovf_out=1.
REQ-033 Back-to-back 100 random inputs, out_ready=1 -> one result per cycle, matching A+B+cin in order.
REQ-034 Fill pipe, out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts, sum_out stable, no loss/duplication on release.
REQ-035 flush with 2 ops in flight -> out_valid=0 next cycle, flushed results never appear; rst mid-stream -> all outputs 0, in_ready=1.
